tt_lut_engine: RTL and testbench

- Programmable, registered truth-table evaluator.
- Maps an N_IN-bit input vector to an N_OUT-bit output vector through a 2^N_IN-entry table loaded at run time over a write handshake.
- Double-buffered: a shadow table is loaded while the active table keeps evaluating, then swapped atomically on commit.
- Used as the generic logic-function block for synthesised netlists in place of hard-coded case tables.

---
 rtl/tt_lut_engine_pkg.sv | 19 +
 rtl/tt_lut_engine_if.sv | 48 ++++
 rtl/tt_lut_bank.sv | 57 +++++
 rtl/tt_lut_engine.sv | 143 ++++++++++++++
 tb/tb_tt_lut_engine.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tt_lut_engine_pkg.sv
// tt_lut_engine shared types
// FSM encoding and table sizing helper
package tt_lut_engine_pkg;

  localparam logic [1:0] ST_UNCFG  = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_SWAP   = 2'd2;

  typedef enum logic [1:0] {
    UNCFG  = ST_UNCFG,
    ACTIVE = ST_ACTIVE,
    SWAP   = ST_SWAP
  } state_e;

  function automatic int depth(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/tt_lut_engine_if.sv
// tt_lut_engine_if: config and evaluation bundle
// master issues requests, slave returns status
interface tt_lut_engine_if #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 3
);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [N_IN-1:0]  cfg_addr;
  logic [N_OUT-1:0] cfg_data;
  logic             cfg_commit;
  logic             cfg_err;
  logic             configured;
  logic             in_valid;
  logic [N_IN-1:0]  in_vec;
  logic             out_valid;
  logic [N_OUT-1:0] out_vec;

  modport master (
    output cfg_valid,
    output cfg_addr,
    output cfg_data,
    output cfg_commit,
    output in_valid,
    output in_vec,
    input  cfg_ready,
    input  cfg_err,
    input  configured,
    input  out_valid,
    input  out_vec
  );

  modport slave (
    input  cfg_valid,
    input  cfg_addr,
    input  cfg_data,
    input  cfg_commit,
    input  in_valid,
    input  in_vec,
    output cfg_ready,
    output cfg_err,
    output configured,
    output out_valid,
    output out_vec
  );

endinterface

// File: rtl/tt_lut_bank.sv
// tt_lut_bank: DEPTH x N_OUT register array
// one write port, whole-table load, combinational read
module tt_lut_bank
  import tt_lut_engine_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         we_i,
  input  logic [N_IN-1:0]              waddr_i,
  input  logic [N_OUT-1:0]             wdata_i,
  input  logic                         ld_i,
  input  logic [depth(N_IN)*N_OUT-1:0] ld_data_i,
  input  logic [N_IN-1:0]              raddr_i,
  output logic [N_OUT-1:0]             rdata_o,
  output logic [depth(N_IN)*N_OUT-1:0] tbl_o
);

  localparam int DEPTH = depth(N_IN);

  logic [N_OUT-1:0] mem_q [DEPTH];
  logic [N_OUT-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (ld_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] = ld_data_i[i*N_OUT +: N_OUT];
      end
    end
    if (we_i) begin
      mem_d[waddr_i] = wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    tbl_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      tbl_o[i*N_OUT +: N_OUT] = mem_q[i];
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/tt_lut_engine.sv
// tt_lut_engine: double-buffered truth-table evaluator
// shadow bank loads while active bank evaluates
module tt_lut_engine
  import tt_lut_engine_pkg::*;
#(
  parameter int N_IN          = 4,
  parameter int N_OUT         = 3,
  parameter bit ALLOW_PARTIAL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  tt_lut_engine_if.slave   bus
);

  localparam int DEPTH = depth(N_IN);
  localparam int TW    = DEPTH * N_OUT;

  state_e state_q, state_d;

  logic [DEPTH-1:0] written_q, written_d;
  logic [DEPTH-1:0] wr_bit;
  logic             err_q, err_d;
  logic             cfgd_q, cfgd_d;
  logic             ov_q, ov_d;
  logic [N_OUT-1:0] ovec_q, ovec_d;

  logic             rdy;
  logic             wr_en;
  logic             commit;
  logic             complete;
  logic             swap;
  logic             fire;
  logic [N_OUT-1:0] act_rd;
  logic [TW-1:0]    shd_tbl;
  logic [TW-1:0]    act_tbl_unused;
  logic [N_OUT-1:0] shd_rd_unused;

  assign rdy    = (state_q != SWAP);
  assign wr_en  = bus.cfg_valid && rdy;
  assign commit = bus.cfg_commit && rdy;
  assign fire   = bus.in_valid && cfgd_q;

  // a write landing with the commit counts toward completeness
  always_comb begin
    wr_bit = '0;
    if (wr_en) begin
      wr_bit[bus.cfg_addr] = 1'b1;
    end
  end

  assign complete = &(written_q | wr_bit);

  always_comb begin
    state_d   = state_q;
    written_d = written_q | wr_bit;
    err_d     = 1'b0;
    cfgd_d    = cfgd_q;
    swap      = 1'b0;
    unique case (state_q)
      UNCFG, ACTIVE: begin
        if (commit) begin
          if (complete || ALLOW_PARTIAL) begin
            state_d = SWAP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SWAP: begin
        state_d   = ACTIVE;
        written_d = '0;
        cfgd_d    = 1'b1;
        swap      = 1'b1;
      end
      default: begin
        state_d = UNCFG;
      end
    endcase
  end

  always_comb begin
    ov_d   = fire;
    ovec_d = fire ? act_rd : ovec_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= UNCFG;
      written_q <= '0;
      err_q     <= 1'b0;
      cfgd_q    <= 1'b0;
      ov_q      <= 1'b0;
      ovec_q    <= '0;
    end else begin
      state_q   <= state_d;
      written_q <= written_d;
      err_q     <= err_d;
      cfgd_q    <= cfgd_d;
      ov_q      <= ov_d;
      ovec_q    <= ovec_d;
    end
  end

  tt_lut_bank #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT)
  ) u_shadow (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (wr_en),
    .waddr_i   (bus.cfg_addr),
    .wdata_i   (bus.cfg_data),
    .ld_i      (1'b0),
    .ld_data_i ('0),
    .raddr_i   ('0),
    .rdata_o   (shd_rd_unused),
    .tbl_o     (shd_tbl)
  );

  // active only ever changes by whole-table copy
  tt_lut_bank #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT)
  ) u_active (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (1'b0),
    .waddr_i   ('0),
    .wdata_i   ('0),
    .ld_i      (swap),
    .ld_data_i (shd_tbl),
    .raddr_i   (bus.in_vec),
    .rdata_o   (act_rd),
    .tbl_o     (act_tbl_unused)
  );

  assign bus.cfg_ready  = rdy;
  assign bus.cfg_err    = err_q;
  assign bus.configured = cfgd_q;
  assign bus.out_valid  = ov_q;
  assign bus.out_vec    = ovec_q;

endmodule

// File: tb/tb_tt_lut_engine.sv
// tb_tt_lut_engine: strict and partial-commit instances
// driven together and checked against a table model
module tb_tt_lut_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       d_valid;
  logic       d_commit;
  logic       d_inval;
  logic [3:0] d_addr;
  logic [3:0] d_vec;
  logic [2:0] d_data;

  int n_vec = 0;
  int n_err = 0;

  tt_lut_engine_if #(.N_IN(4), .N_OUT(3)) if0 ();
  tt_lut_engine_if #(.N_IN(4), .N_OUT(3)) if1 ();

  assign if0.cfg_valid  = d_valid;
  assign if0.cfg_addr   = d_addr;
  assign if0.cfg_data   = d_data;
  assign if0.cfg_commit = d_commit;
  assign if0.in_valid   = d_inval;
  assign if0.in_vec     = d_vec;
  assign if1.cfg_valid  = d_valid;
  assign if1.cfg_addr   = d_addr;
  assign if1.cfg_data   = d_data;
  assign if1.cfg_commit = d_commit;
  assign if1.in_valid   = d_inval;
  assign if1.in_vec     = d_vec;

  tt_lut_engine #(
    .N_IN(4), .N_OUT(3), .ALLOW_PARTIAL(1'b0)
  ) u0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  tt_lut_engine #(
    .N_IN(4), .N_OUT(3), .ALLOW_PARTIAL(1'b1)
  ) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  always #5 clk = ~clk;

  // model: two tables per instance, a written set, a pending-swap flag
  logic [2:0] m_shd  [2][16];
  logic [2:0] m_act  [2][16];
  bit         m_wr   [2][16];
  bit         m_swap [2];
  bit         m_cfg  [2];
  bit         m_err  [2];
  bit         m_ov   [2];
  logic [2:0] m_ovec [2];

  task automatic mclr();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) begin
        m_shd[k][i] = '0;
        m_act[k][i] = '0;
        m_wr[k][i]  = 1'b0;
      end
      m_swap[k] = 1'b0;
      m_cfg[k]  = 1'b0;
      m_err[k]  = 1'b0;
      m_ov[k]   = 1'b0;
      m_ovec[k] = '0;
    end
  endtask

  task automatic mstep(input int k);
    bit         nov;
    bit         nerr;
    logic [2:0] nvec;
    int         cnt;
    nov  = d_inval && m_cfg[k];
    nvec = nov ? m_act[k][d_vec] : m_ovec[k];
    nerr = 1'b0;
    if (m_swap[k]) begin
      for (int i = 0; i < 16; i++) begin
        m_act[k][i] = m_shd[k][i];
        m_wr[k][i]  = 1'b0;
      end
      m_cfg[k]  = 1'b1;
      m_swap[k] = 1'b0;
    end else begin
      if (d_valid) begin
        m_shd[k][d_addr] = d_data;
        m_wr[k][d_addr]  = 1'b1;
      end
      if (d_commit) begin
        cnt = 0;
        for (int i = 0; i < 16; i++) cnt += m_wr[k][i] ? 1 : 0;
        if (cnt == 16 || k == 1) m_swap[k] = 1'b1;
        else nerr = 1'b1;
      end
    end
    m_ov[k]   = nov;
    m_ovec[k] = nvec;
    m_err[k]  = nerr;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mclr();
    end else begin
      mstep(0);
      mstep(1);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input int k, input logic rdy, input logic err,
                     input logic cfgd, input logic ov,
                     input logic [2:0] vec);
    chk($sformatf("u%0d.cfg_ready", k), 32'(rdy), 32'(!m_swap[k]));
    chk($sformatf("u%0d.cfg_err", k), 32'(err), 32'(m_err[k]));
    chk($sformatf("u%0d.configured", k), 32'(cfgd), 32'(m_cfg[k]));
    chk($sformatf("u%0d.out_valid", k), 32'(ov), 32'(m_ov[k]));
    chk($sformatf("u%0d.out_vec", k), 32'(vec), 32'(m_ovec[k]));
  endtask

  always @(negedge clk) begin
    cmp(0, if0.cfg_ready, if0.cfg_err, if0.configured,
        if0.out_valid, if0.out_vec);
    cmp(1, if1.cfg_ready, if1.cfg_err, if1.configured,
        if1.out_valid, if1.out_vec);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [2:0] v);
    d_valid = 1'b1;
    d_addr  = a;
    d_data  = v;
    tick();
    d_valid = 1'b0;
  endtask

  task automatic commit();
    d_commit = 1'b1;
    tick();
    d_commit = 1'b0;
  endtask

  task automatic ev(input logic [3:0] v);
    d_inval = 1'b1;
    d_vec   = v;
    tick();
    d_inval = 1'b0;
  endtask

  function automatic logic [2:0] tbl_a(input int i);
    if (i == 9) return 3'b001;
    if (i == 10 || i == 11) return 3'b010;
    if (i >= 12) return 3'b100;
    return 3'b000;
  endfunction

  initial begin
    rst_n    = 1'b0;
    d_valid  = 1'b0;
    d_commit = 1'b0;
    d_inval  = 1'b0;
    d_addr   = '0;
    d_vec    = '0;
    d_data   = '0;
    tick();
    tick();
    chk("rst_ready", 32'(if0.cfg_ready), 32'd1);
    chk("rst_cfgd", 32'(if0.configured), 32'd0);
    chk("rst_ov", 32'(if1.out_valid), 32'd0);
    rst_n = 1'b1;
    tick();

    // load and swap, with ignored traffic during SWAP
    for (int i = 0; i < 16; i++) wr(4'(i), tbl_a(i));
    commit();
    chk("swap_ready0", 32'(if0.cfg_ready), 32'd0);
    chk("swap_ready1", 32'(if1.cfg_ready), 32'd0);
    d_valid  = 1'b1;
    d_addr   = 4'd3;
    d_data   = 3'b101;
    d_commit = 1'b1;
    tick();
    d_valid  = 1'b0;
    d_commit = 1'b0;
    chk("load_cfgd", 32'(if0.configured), 32'd1);
    chk("load_ready", 32'(if0.cfg_ready), 32'd1);
    tick();
    chk("no_reswap", 32'(if0.cfg_ready), 32'd1);
    chk("no_err", 32'(if0.cfg_err), 32'd0);
    ev(4'b1010);
    chk("ev_1010", 32'(if0.out_vec), 32'(3'b010));
    chk("ev_1010_v", 32'(if0.out_valid), 32'd1);
    chk("model_1010", 32'(m_ovec[0]), 32'(3'b010));
    ev(4'b1001);
    chk("ev_1001", 32'(if0.out_vec), 32'(3'b001));
    ev(4'b0111);
    chk("ev_0111", 32'(if0.out_vec), 32'(3'b000));

    // partial reload: strict rejects, partial swaps
    wr(4'd0, 3'b110);
    commit();
    chk("part_err0", 32'(if0.cfg_err), 32'd1);
    chk("part_err1", 32'(if1.cfg_err), 32'd0);
    chk("part_rdy1", 32'(if1.cfg_ready), 32'd0);
    tick();
    chk("part_err0_clr", 32'(if0.cfg_err), 32'd0);
    ev(4'd0);
    chk("part_e0_u1", 32'(if1.out_vec), 32'(3'b110));
    chk("part_e0_u0", 32'(if0.out_vec), 32'(3'b000));
    ev(4'd12);
    chk("part_e12", 32'(if1.out_vec), 32'(3'b100));
    ev(4'd3);
    chk("swap_ignored_e3", 32'(if1.out_vec), 32'(3'b000));

    // atomic swap while streaming evaluations
    for (int i = 0; i < 16; i++) wr(4'(i), 3'b111);
    commit();
    tick();
    d_inval = 1'b1;
    d_vec   = 4'b0101;
    for (int i = 0; i < 16; i++) wr(4'(i), 3'b000);
    commit();
    chk("atom_pre", 32'(if0.out_vec), 32'(3'b111));
    tick();
    chk("atom_edge0", 32'(if0.out_vec), 32'(3'b111));
    chk("atom_edge1", 32'(if1.out_vec), 32'(3'b111));
    tick();
    chk("atom_new0", 32'(if0.out_vec), 32'(3'b000));
    chk("atom_new1", 32'(if1.out_vec), 32'(3'b000));

    // reset in the middle of a load
    d_vec = 4'd12;
    for (int i = 0; i < 5; i++) wr(4'(i), 3'b111);
    d_valid = 1'b1;
    d_addr  = 4'd5;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_ov", 32'(if0.out_valid), 32'd0);
    chk("mrst_vec", 32'(if1.out_vec), 32'd0);
    chk("mrst_cfgd", 32'(if0.configured), 32'd0);
    chk("mrst_ready", 32'(if1.cfg_ready), 32'd1);
    d_valid = 1'b0;
    d_inval = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    ev(4'd12);
    chk("mrst_ev_ov", 32'(if0.out_valid), 32'd0);
    chk("mrst_ev_vec", 32'(if0.out_vec), 32'd0);

    // incomplete commit, then completed by a same-cycle write
    for (int i = 0; i < 16; i++) begin
      if (i != 7) wr(4'(i), 3'(i));
    end
    commit();
    chk("inc_err", 32'(if0.cfg_err), 32'd1);
    chk("inc_cfgd", 32'(if0.configured), 32'd0);
    ev(4'd3);
    chk("inc_err_clr", 32'(if0.cfg_err), 32'd0);
    chk("inc_ov", 32'(if0.out_valid), 32'd0);
    d_commit = 1'b1;
    wr(4'd7, 3'b111);
    d_commit = 1'b0;
    chk("fill_swap", 32'(if0.cfg_ready), 32'd0);
    tick();
    chk("fill_cfgd", 32'(if0.configured), 32'd1);
    ev(4'd7);
    chk("fill_e7", 32'(if0.out_vec), 32'(3'b111));
    ev(4'd3);
    chk("fill_e3", 32'(if0.out_vec), 32'(3'b011));

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      d_valid  = ($urandom_range(3) != 0);
      d_addr   = 4'($urandom_range(15));
      d_data   = 3'($urandom_range(7));
      d_commit = ($urandom_range(15) == 0);
      d_inval  = ($urandom_range(1) == 1);
      d_vec    = 4'($urandom_range(15));
      rst_n    = ($urandom_range(499) != 0);
      tick();
    end
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
